pipe_elastic_31: RTL and testbench
==================================

PIPE_ELASTIC_31 -- requirements
Module: pipe_elastic_31

Interface
REQ-001 The block SHALL have parameter WIDTH, default 31, giving the data width.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-005 The block SHALL have port d, input, WIDTH bits: upstream data.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream data on d is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept d this cycle.
REQ-008 The block SHALL have port q, output, WIDTH bits: head-of-buffer data to downstream.
REQ-009 The block SHALL have port out_valid, output, 1 bit: q is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts q this cycle.
REQ-011 The block SHALL have port count, output, 2 bits: current occupancy, 0 to 2.

Function
REQ-012 The block SHALL be a two-entry, first-in first-out elastic buffer, the flow-controlled counterpart of the fixed two-stage register pipeline.
REQ-013 A push SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-014 A pop SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-015 The state machine SHALL have three states: EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-016 EMPTY: push -> ONE; otherwise hold.
REQ-017 ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop together -> ONE, with the new entry becoming head.
REQ-018 FULL: pop -> ONE, with the second entry becoming head; a push is impossible in FULL.
REQ-019 in_ready SHALL be 1 exactly when count is not 2; it SHALL be decoded from state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 exactly when count is not 0; it SHALL be decoded from state only.
REQ-021 q SHALL present the oldest entry whenever out_valid is 1, and SHALL be all zeros when out_valid is 0.
REQ-022 Latency SHALL be one cycle: data pushed at edge N appears on q, with out_valid 1, after edge N, provided no older entry is present.
REQ-023 Data SHALL leave in push order, with no loss or duplication.
REQ-024 While out_valid is 1 and out_ready is 0, q SHALL stay stable.
REQ-025 Sustained throughput SHALL be one word per cycle when in_valid and out_ready are held at 1.
REQ-026 flush SHALL take priority over push and pop: the next state is EMPTY and any word presented that cycle is dropped.
REQ-027 count SHALL be a registered occupancy value and SHALL never exceed 2 or underflow.

Reset
REQ-028 Asserting rst SHALL immediately force the state to EMPTY, independent of clk.
REQ-029 While rst is asserted: count = 0, out_valid = 0, q = 0, in_ready = 1.
REQ-030 Storage contents after reset SHALL be unobservable; no stale data may appear on q.
REQ-031 Asserting rst mid-transfer SHALL discard all entries; no pop may be reported for them after reset release.
REQ-032 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 Single word: after reset, push d=31'h1234567 with out_ready=0 -> next cycle q=31'h1234567, out_valid=1, count=1, in_ready=1.
REQ-034 Fill and backpressure: push A=1 then B=2 with out_ready=0 -> count=2, in_ready=0; a third word C=3 is not accepted; raise out_ready -> q=1, then q=2, then out_valid=0.
REQ-035 Streaming: in_valid=1 and out_ready=1 for 100 cycles with d incrementing from 0 -> q equals the pushed value one cycle later, count stays 1, no gaps.
REQ-036 Simultaneous events in ONE: head=5, push 6 and pop together -> count stays 1 and q=6 next cycle.
REQ-037 Flush: count=2, flush=1 with in_valid=1 and d=9 -> next cycle count=0, out_valid=0, q=0, and 9 is never output.
REQ-038 Asynchronous reset: assert rst between clock edges while count=2 -> out_valid and count fall to 0 before the next edge; after release, push 7 -> q=7 one cycle later.

Source files
------------

// File: rtl/pipe_elastic_31.sv
`default_nettype none
// ============================================================================
// Module      : pipe_elastic_31
// Description : Two-entry first-in first-out elastic buffer with valid/ready
//               handshakes on both sides, synchronous flush and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_elastic_31 #(
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // State code doubles as the occupancy value driven on count.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_state != c_FULL);
    assign out_valid = (r_state != c_EMPTY);
    assign count     = r_state;
    assign q         = out_valid ? r_head : '0;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_state <= c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_push) begin
                        r_head  <= d;
                        r_state <= c_ONE;
                    end
                end
                c_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= d;
                    end else if (w_push) begin
                        r_tail  <= d;
                        r_state <= c_FULL;
                    end else if (w_pop) begin
                        r_state <= c_EMPTY;
                    end
                end
                c_FULL: begin
                    // in_ready is low here, so only a pop can occur.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= c_ONE;
                    end
                end
                default: r_state <= c_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_elastic_31.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_elastic_31
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_elastic_31;

    localparam int WIDTH = 31;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       count;

    int n_vec;
    int n_err;

    typedef struct {
        logic             flush;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic [1:0]       cnt;
        logic             ov;
        logic             ir;
        logic [WIDTH-1:0] q;
    } vec_t;

    vec_t tbl [10];

    logic [WIDTH-1:0] mq [$];

    pipe_elastic_31 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [1:0] ec, input logic eov,
                         input logic eir, input logic [WIDTH-1:0] eq);
        n_vec++;
        if (count !== ec || out_valid !== eov || in_ready !== eir || q !== eq) begin
            n_err++;
            $display("FAIL %s: got count=%0d out_valid=%b in_ready=%b q=%h, expected count=%0d out_valid=%b in_ready=%b q=%h",
                     name, count, out_valid, in_ready, q, ec, eov, eir, eq);
        end
    endtask

    // Apply inputs, clock once, and land 1 ns after the active edge.
    task automatic step(input logic f, input logic iv, input logic [WIDTH-1:0] dd,
                        input logic ordy);
        flush     = f;
        in_valid  = iv;
        d         = dd;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //          flush iv d             ordy cnt ov ir q
        tbl[0] = '{1'b0, 1'b1, 31'h1234567, 1'b0, 2'd1, 1'b1, 1'b1, 31'h1234567};
        tbl[1] = '{1'b0, 1'b1, 31'h2,       1'b0, 2'd2, 1'b1, 1'b0, 31'h1234567};
        tbl[2] = '{1'b0, 1'b1, 31'h3,       1'b0, 2'd2, 1'b1, 1'b0, 31'h1234567};
        tbl[3] = '{1'b0, 1'b0, 31'h0,       1'b1, 2'd1, 1'b1, 1'b1, 31'h2};
        tbl[4] = '{1'b0, 1'b1, 31'h6,       1'b1, 2'd1, 1'b1, 1'b1, 31'h6};
        tbl[5] = '{1'b0, 1'b0, 31'h0,       1'b1, 2'd0, 1'b0, 1'b1, 31'h0};
        tbl[6] = '{1'b0, 1'b0, 31'h0,       1'b1, 2'd0, 1'b0, 1'b1, 31'h0};
        tbl[7] = '{1'b0, 1'b1, 31'h5,       1'b0, 2'd1, 1'b1, 1'b1, 31'h5};
        tbl[8] = '{1'b1, 1'b1, 31'h9,       1'b0, 2'd0, 1'b0, 1'b1, 31'h0};
        tbl[9] = '{1'b0, 1'b0, 31'h0,       1'b1, 2'd0, 1'b0, 1'b1, 31'h0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        d         = 31'h7fff_ffff;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 2'd0, 1'b0, 1'b1, '0);
        #2 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check($sformatf("table[%0d]", i), tbl[i].cnt, tbl[i].ov, tbl[i].ir, tbl[i].q);
        end

        // Fill, backpressure, rejected third word, then drain in order.
        step(0, 1, 31'h1, 0); check("fill_a", 2'd1, 1, 1, 31'h1);
        step(0, 1, 31'h2, 0); check("fill_b", 2'd2, 1, 0, 31'h1);
        step(0, 1, 31'h3, 0); check("fill_c_rejected", 2'd2, 1, 0, 31'h1);
        step(0, 0, 31'h0, 1); check("drain_a", 2'd1, 1, 1, 31'h2);
        step(0, 0, 31'h0, 1); check("drain_b", 2'd0, 0, 1, 31'h0);

        // Streaming at one word per cycle.
        step(0, 1, 31'h0, 1); check("stream_0", 2'd1, 1, 1, 31'h0);
        for (int i = 1; i < 100; i++) begin
            step(0, 1, WIDTH'(i), 1);
            check($sformatf("stream_%0d", i), 2'd1, 1, 1, WIDTH'(i));
        end
        step(0, 0, 31'h0, 1); check("stream_end", 2'd0, 0, 1, 31'h0);

        // Flush at FULL drops both entries and the word offered alongside.
        step(0, 1, 31'h11, 0);
        step(0, 1, 31'h12, 0); check("flush_pre", 2'd2, 1, 0, 31'h11);
        step(1, 1, 31'h9, 0);  check("flush", 2'd0, 0, 1, 31'h0);
        step(0, 0, 31'h0, 1);  check("flush_after", 2'd0, 0, 1, 31'h0);

        // Asynchronous reset between edges while FULL.
        step(0, 1, 31'h21, 0);
        step(0, 1, 31'h22, 0); check("areset_pre", 2'd2, 1, 0, 31'h21);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("areset_mid_cycle", 2'd0, 0, 1, 31'h0);
        #2 rst = 1'b0;
        step(0, 1, 31'h7, 0); check("areset_push7", 2'd1, 1, 1, 31'h7);
        step(0, 0, 31'h0, 1); check("areset_drain", 2'd0, 0, 1, 31'h0);

        // Randomized traffic against a queue model.
        mq.delete();
        for (int i = 0; i < 400; i++) begin
            logic f, iv, ordy, do_push, do_pop;
            logic [WIDTH-1:0] dd, eq;
            f    = ($urandom_range(0, 15) == 0);
            iv   = $urandom_range(0, 1) == 1;
            ordy = $urandom_range(0, 3) != 0;
            dd   = WIDTH'($urandom);
            do_push = iv && (mq.size() < 2);
            do_pop  = ordy && (mq.size() > 0);
            step(f, iv, dd, ordy);
            if (f) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(dd);
            end
            eq = (mq.size() > 0) ? mq[0] : '0;
            check($sformatf("random_%0d", i), 2'(mq.size()), mq.size() > 0,
                  mq.size() < 2, eq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
